// File: rtl/m2v_coef_reader_if.sv
// Coefficient-side and IDCT-side signals of the MPEG-2 coefficient reader.
// The master is the environment: the sequencer, the coefficient source and the IDCT sink.
interface m2v_coef_reader_if #(
   parameter int OUT_W = 12
);
   logic                    ready_coef;
   logic                    block_start;
   logic                    s2_enable;
   logic                    s2_coded;
   logic                    coef_sign;
   logic [11:0]             coef_data;
   logic                    coef_next;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_last;
   logic                    err_ovf;

   modport master (
      input  ready_coef, coef_next, out_valid, out_data, out_last, err_ovf,
      output block_start, s2_enable, s2_coded, coef_sign, coef_data, out_ready
   );

   modport slave (
      output ready_coef, coef_next, out_valid, out_data, out_last, err_ovf,
      input  block_start, s2_enable, s2_coded, coef_sign, coef_data, out_ready
   );
endinterface

// File: rtl/m2v_coef_reader.sv
// Pulls 64 sign-magnitude coefficients per block into a ping-pong buffer.
// Streams each buffered block in raster order to the IDCT over valid/ready.
module m2v_coef_reader #(
   parameter int FETCH_LAT = 2,
   parameter int OUT_W     = 12
) (
   input logic              clk,
   input logic              reset_n,
   input logic              softreset,
   m2v_coef_reader_if.slave bus
);
   localparam int SAT_MAX = (1 <<< (OUT_W - 1)) - 1;
   localparam int SAT_MIN = -(1 <<< (OUT_W - 1));

   typedef enum logic [1:0] {F_IDLE, F_WAIT, F_FETCH, F_COMMIT} fill_t;
   typedef enum logic {D_IDLE, D_SEND} drain_t;

   fill_t                   fill_q, fill_d;
   logic [2:0]              lat_q, lat_d;
   logic [5:0]              idx_q, idx_d;
   logic                    wr_q, wr_d;
   logic                    coef_next_q, coef_next_d;
   logic [1:0]              full_q, full_d;
   logic [1:0]              zero_q, zero_d;
   logic                    err_q, err_d;
   drain_t                  drain_q, drain_d;
   logic                    rd_q, rd_d;
   logic [5:0]              cnt_q, cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;

   logic signed [OUT_W-1:0] mem [0:127];

   logic       ready_coef;
   logic [1:0] commit_mask, set_mask, clr_mask, full_now, zero_now;
   logic       set_zero;
   logic       load;
   logic       ld_bank;
   logic [5:0] ld_idx;

   function automatic logic signed [OUT_W-1:0] sat_coef(input logic sign, input logic [11:0] mag);
      logic signed [31:0] v;
      v = $signed({20'd0, mag});
      if (sign) v = -v;
      if (v > SAT_MAX) v = SAT_MAX;
      else if (v < SAT_MIN) v = SAT_MIN;
      return v[OUT_W-1:0];
   endfunction

   assign ready_coef  = (fill_q == F_IDLE) && !full_q[wr_q];
   assign commit_mask = (fill_q == F_COMMIT) ? (2'b01 << wr_q) : 2'b00;
   // A bank committing this cycle is visible to the drain at once, saving a cycle of latency.
   assign full_now    = full_q | commit_mask;
   assign zero_now    = zero_q & ~commit_mask;

   always_comb begin
      fill_d      = fill_q;
      lat_d       = lat_q;
      idx_d       = idx_q;
      wr_d        = wr_q;
      coef_next_d = coef_next_q;
      err_d       = err_q;
      set_mask    = 2'b00;
      set_zero    = 1'b0;
      if (bus.block_start && !ready_coef) err_d = 1'b1;
      case (fill_q)
         F_IDLE: if (bus.block_start && ready_coef && bus.s2_enable) begin
            if (!bus.s2_coded) begin
               set_mask = 2'b01 << wr_q;
               set_zero = 1'b1;
               wr_d     = ~wr_q;
            end else if (FETCH_LAT == 1) begin
               fill_d      = F_FETCH;
               coef_next_d = 1'b1;
               idx_d       = '0;
            end else begin
               fill_d = F_WAIT;
               lat_d  = 3'(FETCH_LAT - 1);
            end
         end
         F_WAIT: begin
            lat_d = lat_q - 3'd1;
            if (lat_q == 3'd1) begin
               fill_d      = F_FETCH;
               coef_next_d = 1'b1;
               idx_d       = '0;
            end
         end
         F_FETCH: begin
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'd63) begin
               fill_d      = F_COMMIT;
               coef_next_d = 1'b0;
            end
         end
         F_COMMIT: begin
            set_mask = commit_mask;
            wr_d     = ~wr_q;
            fill_d   = F_IDLE;
         end
         default: fill_d = F_IDLE;
      endcase
   end

   always_comb begin
      drain_d     = drain_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      clr_mask    = 2'b00;
      load        = 1'b0;
      ld_bank     = rd_q;
      ld_idx      = '0;
      case (drain_q)
         D_IDLE: if (full_now[rd_q]) begin
            load    = 1'b1;
            cnt_d   = '0;
            drain_d = D_SEND;
         end
         D_SEND: if (bus.out_ready) begin
            if (cnt_q == 6'd63) begin
               clr_mask = 2'b01 << rd_q;
               rd_d     = ~rd_q;
               cnt_d    = '0;
               if (full_now[~rd_q]) begin
                  load    = 1'b1;
                  ld_bank = ~rd_q;
               end else begin
                  drain_d     = D_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end
            end else begin
               load   = 1'b1;
               ld_idx = cnt_q + 6'd1;
               cnt_d  = cnt_q + 6'd1;
            end
         end
         default: drain_d = D_IDLE;
      endcase
      // Registered RAM read: the next beat is fetched while the current one is presented.
      out_data_d = out_data_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_last_d  = (ld_idx == 6'd63);
         out_data_d  = zero_now[ld_bank] ? '0 : mem[{ld_bank, ld_idx}];
      end
   end

   assign full_d = (full_q | set_mask) & ~clr_mask;
   assign zero_d = set_zero ? (zero_q | set_mask) : (zero_q & ~set_mask);

   always_ff @(posedge clk) begin
      if (coef_next_q) mem[{wr_q, idx_q}] <= sat_coef(bus.coef_sign, bus.coef_data);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_q <= F_IDLE;  lat_q <= '0;  idx_q <= '0;  wr_q <= 1'b0;
         coef_next_q <= 1'b0;  full_q <= '0;  zero_q <= '0;  err_q <= 1'b0;
         drain_q <= D_IDLE;  rd_q <= 1'b0;  cnt_q <= '0;
         out_valid_q <= 1'b0;  out_last_q <= 1'b0;  out_data_q <= '0;
      end else if (softreset) begin
         fill_q <= F_IDLE;  lat_q <= '0;  idx_q <= '0;  wr_q <= 1'b0;
         coef_next_q <= 1'b0;  full_q <= '0;  zero_q <= '0;  err_q <= 1'b0;
         drain_q <= D_IDLE;  rd_q <= 1'b0;  cnt_q <= '0;
         out_valid_q <= 1'b0;  out_last_q <= 1'b0;  out_data_q <= '0;
      end else begin
         fill_q <= fill_d;  lat_q <= lat_d;  idx_q <= idx_d;  wr_q <= wr_d;
         coef_next_q <= coef_next_d;  full_q <= full_d;  zero_q <= zero_d;  err_q <= err_d;
         drain_q <= drain_d;  rd_q <= rd_d;  cnt_q <= cnt_d;
         out_valid_q <= out_valid_d;  out_last_q <= out_last_d;  out_data_q <= out_data_d;
      end
   end

   assign bus.ready_coef = ready_coef;
   assign bus.coef_next  = coef_next_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_last   = out_last_q;
   assign bus.err_ovf    = err_q;
endmodule
